wb_arbiter_2m: RTL

- Two-master to one-slave Wishbone arbiter that lets the core's instruction and data ports share a single external Wishbone slave bus (memory/peripheral crossbar port).
- Sits between the MiniMIPS32 top-level iwishbone/dwishbone master outputs and the SoC slave fabric.
- Holds each grant for the whole bus cycle (cyc), alternates priority between masters (round-robin), and includes a bus-timeout watchdog that returns an error to a master whose access is never acknowledged.

---
 rtl/wb_arbiter_2m.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant held for the whole
// bus cycle, plus a watchdog that errors out a master whose access is never acked.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_e;

  localparam logic            WD_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TERM  = WD_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_e          state_q, state_d;
  logic            last_q, last_d;   // 1: m1 was the last owner
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) state_d = G0;
        else if (m1_cyc_i)                     state_d = G1;
      end
      G0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? G1 : IDLE;
        end
      end
      G1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? G0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    gnt_o    = 2'b00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    case (state_q)
      G0: begin
        gnt_o    = 2'b01;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i & ~err_q;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
        m0_err_o = err_q;
      end
      G1: begin
        gnt_o    = 2'b10;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i & ~err_q;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
        m1_err_o = err_q;
      end
      default: ;
    endcase
  end

  // err_q is only raised while the grant is unchanged, so it always belongs to the current owner
  always_comb begin
    cnt_d = '0;
    err_d = 1'b0;
    if (WD_EN && (state_q != IDLE) && (state_d == state_q) && s_stb_o && !s_ack_i) begin
      if (cnt_q == TERM) err_d = 1'b1;
      else               cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
